// File: rtl/simon_pad_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pad_renderer
//  Purpose  : Draws NUM_PADS rectangular Simon pads in a PAD_COLS-wide grid
//             over a background colour. Pads are dim, or bright while the flash
//             sequencer lights them (lit period, dark gap, done pulse).
//  Options  : SIMON_PAD_OUTLINE_EN - black OUTLINE_PX-wide border on each pad
//  Revision : 1.0 - initial release
// ============================================================================
module simon_pad_renderer #(
  parameter int          NUM_PADS    = 4,
  parameter int          PAD_COLS    = 2,
  parameter int          PAD_W       = 300,
  parameter int          PAD_H       = 220,
  parameter int          GAP_PX      = 13,
  parameter int          H_ORIGIN    = 144,
  parameter int          V_ORIGIN    = 35,
  parameter int          FLASH_TICKS = 25000000,
  parameter int          DARK_TICKS  = 5000000,
  parameter logic [11:0] BG_COLOR    = 12'h0F0,
  parameter int          OUTLINE_PX  = 3,
  localparam int         IDX_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bright,
  input  logic [9:0]              hCount,
  input  logic [9:0]              vCount,
  input  logic [12*NUM_PADS-1:0]  pad_colors,
  input  logic                    flash_valid,
  input  logic [IDX_W-1:0]        flash_pad,
  output logic                    flash_ready,
  output logic                    flash_done,
  output logic [IDX_W-1:0]        lit_pad,
  output logic                    lit_valid,
  output logic [11:0]             rgb,
  output logic [11:0]             background
);

  // Timer must hold the larger of the two reload values.
  localparam int c_MAX_TICKS = (FLASH_TICKS > DARK_TICKS) ? FLASH_TICKS : DARK_TICKS;
  localparam int c_TMR_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS + 1) : 1;
  localparam logic [c_TMR_W-1:0] c_FLASH_LOAD = c_TMR_W'(FLASH_TICKS - 1);
  localparam logic [c_TMR_W-1:0] c_DARK_LOAD  = c_TMR_W'(DARK_TICKS - 1);
  localparam logic [IDX_W:0]     c_NUM_PADS   = (IDX_W + 1)'(NUM_PADS);

`ifdef SIMON_PAD_OUTLINE_EN
  localparam bit c_OUTLINE_ON = 1'b1;
`else
  localparam bit c_OUTLINE_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LIT  = 2'd1,
    S_DARK = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_ready;
  logic               r_done;
  logic [IDX_W-1:0]   r_lit_pad;
  logic               r_lit_valid;
  logic [11:0]        r_rgb;
  logic [11:0]        r_background;

  logic [10:0]         w_h;
  logic [10:0]         w_v;
  logic [NUM_PADS-1:0] w_in_pad;
  logic [NUM_PADS-1:0] w_on_edge;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_hit_edge;
  logic [11:0]         w_hit_col;
  logic [11:0]         w_dim_col;
  logic                w_pad_ok;

  // Widen counters by one bit so pad-edge sums never wrap.
  assign w_h = {1'b0, hCount};
  assign w_v = {1'b0, vCount};

  // Out-of-range pad indices are accepted but must not light anything.
  assign w_pad_ok = ({1'b0, flash_pad} < c_NUM_PADS);

  // Per-pad hit and border tests against elaboration-time rectangle bounds.
  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      localparam int c_X0 = H_ORIGIN + GAP_PX + (gi % PAD_COLS) * (PAD_W + GAP_PX);
      localparam int c_Y0 = V_ORIGIN + GAP_PX + (gi / PAD_COLS) * (PAD_H + GAP_PX);
      localparam logic [10:0] c_XL  = 11'(c_X0);
      localparam logic [10:0] c_XR  = 11'(c_X0 + PAD_W);
      localparam logic [10:0] c_YT  = 11'(c_Y0);
      localparam logic [10:0] c_YB  = 11'(c_Y0 + PAD_H);
      localparam logic [10:0] c_XLI = 11'(c_X0 + OUTLINE_PX);
      localparam logic [10:0] c_XRI = 11'(c_X0 + PAD_W - OUTLINE_PX);
      localparam logic [10:0] c_YTI = 11'(c_Y0 + OUTLINE_PX);
      localparam logic [10:0] c_YBI = 11'(c_Y0 + PAD_H - OUTLINE_PX);

      assign w_in_pad[gi]  = (w_h >= c_XL) && (w_h < c_XR) &&
                             (w_v >= c_YT) && (w_v < c_YB);
      assign w_on_edge[gi] = (w_h < c_XLI) || (w_h >= c_XRI) ||
                             (w_v < c_YTI) || (w_v >= c_YBI);
    end
  endgenerate

  // Priority select of the hit pad: scanning downward lets the lowest index win.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_hit_edge = 1'b0;
    w_hit_col  = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (w_in_pad[i]) begin
        w_hit      = 1'b1;
        w_hit_idx  = IDX_W'(i);
        w_hit_edge = w_on_edge[i];
        w_hit_col  = pad_colors[12*i +: 12];
      end
    end
  end

  // Dim colour: each 4-bit channel divided by four.
  assign w_dim_col = {2'b00, w_hit_col[11:10], 2'b00, w_hit_col[7:6], 2'b00, w_hit_col[3:2]};

  // Pixel register: blanking, pad fill (lit/dim/outline) or background.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= 12'h000;
    end else if (!bright) begin
      r_rgb <= 12'h000;
    end else if (w_hit) begin
      if (c_OUTLINE_ON && w_hit_edge) begin
        r_rgb <= 12'h000;
      end else if (r_lit_valid && (r_lit_pad == w_hit_idx)) begin
        r_rgb <= w_hit_col;
      end else begin
        r_rgb <= w_dim_col;
      end
    end else begin
      r_rgb <= BG_COLOR;
    end
  end

  // Background register: white while in reset, then the configured colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_background <= 12'hFFF;
    end else begin
      r_background <= BG_COLOR;
    end
  end

  // Flash sequencer: IDLE -> LIT (FLASH_TICKS) -> DARK (DARK_TICKS) -> done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_lit_pad   <= '0;
      r_lit_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flash_valid) begin
            r_state <= S_LIT;
            r_timer <= c_FLASH_LOAD;
            r_ready <= 1'b0;
            if (w_pad_ok) begin
              r_lit_valid <= 1'b1;
              r_lit_pad   <= flash_pad;
            end
          end
        end
        S_LIT: begin
          if (r_timer == '0) begin
            r_state     <= S_DARK;
            r_timer     <= c_DARK_LOAD;
            r_lit_valid <= 1'b0;
            r_lit_pad   <= '0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DARK: begin
          if (r_timer == '0) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_timer     <= '0;
          r_ready     <= 1'b1;
          r_lit_valid <= 1'b0;
          r_lit_pad   <= '0;
        end
      endcase
    end
  end

  assign flash_ready = r_ready;
  assign flash_done  = r_done;
  assign lit_pad     = r_lit_pad;
  assign lit_valid   = r_lit_valid;
  assign rgb         = r_rgb;
  assign background  = r_background;

endmodule
`default_nettype wire

// File: tb/tb_simon_pad_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_pad_renderer
//  Purpose  : Scoreboard bench for simon_pad_renderer. A cycle-level reference
//             model (flash timing from the accept time, pixel colour from the
//             pad rectangles) queues expected outputs; a monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simon_pad_renderer;

  localparam int          NUM_PADS   = 4;
  localparam int          PAD_COLS   = 2;
  localparam int          PAD_W      = 300;
  localparam int          PAD_H      = 220;
  localparam int          GAP_PX     = 13;
  localparam int          H_ORIGIN   = 144;
  localparam int          V_ORIGIN   = 35;
  localparam int          F_TICKS    = 10;
  localparam int          D_TICKS    = 4;
  localparam int          OUTLINE_PX = 3;
  localparam logic [11:0] BG         = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic [47:0] pad_colors = '0;
  logic        flash_valid = 1'b0;
  logic [1:0]  flash_pad = '0;
  logic        flash_ready;
  logic        flash_done;
  logic [1:0]  lit_pad;
  logic        lit_valid;
  logic [11:0] rgb;
  logic [11:0] background;

  simon_pad_renderer #(
    .NUM_PADS(NUM_PADS), .PAD_COLS(PAD_COLS), .PAD_W(PAD_W), .PAD_H(PAD_H),
    .GAP_PX(GAP_PX), .H_ORIGIN(H_ORIGIN), .V_ORIGIN(V_ORIGIN),
    .FLASH_TICKS(F_TICKS), .DARK_TICKS(D_TICKS), .BG_COLOR(BG),
    .OUTLINE_PX(OUTLINE_PX)
  ) dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
    .pad_colors(pad_colors), .flash_valid(flash_valid), .flash_pad(flash_pad),
    .flash_ready(flash_ready), .flash_done(flash_done), .lit_pad(lit_pad),
    .lit_valid(lit_valid), .rgb(rgb), .background(background)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [11:0] bg;
    logic        ready;
    logic        done;
    logic        lv;
    logic [1:0]  lp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // Reference-model state: time and pad of the most recent accepted flash.
  int acc = -1;
  int acc_pad = 0;
  bit m_lit = 1'b0;
  int m_litpad = 0;

  function automatic logic [11:0] ref_pixel(input int h, input int v, input bit br,
                                            input logic [47:0] cols, input bit lit, input int lp);
    int x0;
    int y0;
    logic [11:0] c;
    if (!br) return 12'h000;
    for (int i = 0; i < NUM_PADS; i++) begin
      x0 = H_ORIGIN + GAP_PX + (i % PAD_COLS) * (PAD_W + GAP_PX);
      y0 = V_ORIGIN + GAP_PX + (i / PAD_COLS) * (PAD_H + GAP_PX);
      if (h >= x0 && h < x0 + PAD_W && v >= y0 && v < y0 + PAD_H) begin
`ifdef SIMON_PAD_OUTLINE_EN
        if (h < x0 + OUTLINE_PX || h >= x0 + PAD_W - OUTLINE_PX ||
            v < y0 + OUTLINE_PX || v >= y0 + PAD_H - OUTLINE_PX) return 12'h000;
`endif
        c = cols[12*i +: 12];
        if (lit && lp == i) return c;
        return (c >> 2) & 12'h333;
      end
    end
    return BG;
  endfunction

  // Advance one clock: model what the edge just did and queue the expectation.
  task automatic tick(input bit rst_now);
    exp_t e;
    bit   old_rst;
    int   d;
    @(posedge clk);
    #1;
    edge_n++;
    old_rst = rst;
    rst = rst_now;
    if (old_rst || rst_now) begin
      e.rgb = 12'h000; e.bg = 12'hFFF; e.ready = 1'b1; e.done = 1'b0; e.lv = 1'b0; e.lp = 2'd0;
      acc = -1; m_lit = 1'b0; m_litpad = 0;
    end else begin
      e.rgb = ref_pixel(int'(hCount), int'(vCount), bright, pad_colors, m_lit, m_litpad);
      e.bg  = BG;
      if (flash_valid && (acc < 0 || (edge_n - 1 - acc) >= F_TICKS + D_TICKS)) begin
        acc = edge_n;
        acc_pad = int'(flash_pad);
      end
      d = edge_n - acc;
      m_lit    = (acc >= 0) && (d <= F_TICKS - 1) && (acc_pad < NUM_PADS);
      m_litpad = m_lit ? acc_pad : 0;
      e.lv    = m_lit;
      e.lp    = m_litpad[1:0];
      e.ready = (acc < 0) || (d >= F_TICKS + D_TICKS);
      e.done  = (acc >= 0) && (d == F_TICKS + D_TICKS);
    end
    q.push_back(e);
  endtask

  task automatic drive_px(input int h, input int v, input bit b);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h expected=%h", nm, edge_n, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a pixel and status; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rgb",         rgb,                e.rgb);
        chk("background",  background,         e.bg);
        chk("flash_ready", 12'(flash_ready),   12'(e.ready));
        chk("flash_done",  12'(flash_done),    12'(e.done));
        chk("lit_valid",   12'(lit_valid),     12'(e.lv));
        chk("lit_pad",     12'(lit_pad),       12'(e.lp));
      end
    end
  end

  initial begin
    int k;
    int x0;
    int y0;
    pad_colors = {12'h00F, 12'hFF0, 12'h0F0, 12'hF00};

    // Reset, then release with the beam in the gap region.
    drive_px(144, 35, 1'b1);
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b0);

    // Idle pads are dim; blanking forces black.
    drive_px(200, 100, 1'b1); tick(1'b0);
    drive_px(500, 100, 1'b1); tick(1'b0);
    drive_px(500, 100, 1'b0); tick(1'b0);

    // Single flash of pad 2 with a request for pad 1 arriving mid-flash.
    drive_px(200, 300, 1'b1);
    flash_valid = 1'b1; flash_pad = 2'd2;
    tick(1'b0);
    flash_valid = 1'b0;
    repeat (3) tick(1'b0);
    flash_valid = 1'b1; flash_pad = 2'd1;
    repeat (2) tick(1'b0);
    flash_valid = 1'b0;
    repeat (F_TICKS + D_TICKS) tick(1'b0);

    // Request held high: back-to-back flashes of pad 3.
    drive_px(500, 300, 1'b1);
    flash_valid = 1'b1; flash_pad = 2'd3;
    repeat (3 * (F_TICKS + D_TICKS + 1) + 2) tick(1'b0);
    flash_valid = 1'b0;
    repeat (F_TICKS + D_TICKS + 2) tick(1'b0);

    // Reset part-way through a lit period aborts the flash.
    drive_px(200, 100, 1'b1);
    flash_valid = 1'b1; flash_pad = 2'd0;
    tick(1'b0);
    flash_valid = 1'b0;
    repeat (4) tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b0);

    // Corner pixels of pad 0.
    drive_px(158, 49, 1'b1); tick(1'b0);
    drive_px(157, 48, 1'b1); tick(1'b0);
    drive_px(156, 48, 1'b1); tick(1'b0);
    drive_px(456, 267, 1'b1); tick(1'b0);
    drive_px(457, 267, 1'b1); tick(1'b0);
    tick(1'b0);

    // Randomised traffic with pixels concentrated on pad boundaries.
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) pad_colors = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        drive_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 $urandom_range(0, 7) != 0);
      end else begin
        k  = int'($urandom_range(0, NUM_PADS - 1));
        x0 = H_ORIGIN + GAP_PX + (k % PAD_COLS) * (PAD_W + GAP_PX);
        y0 = V_ORIGIN + GAP_PX + (k / PAD_COLS) * (PAD_H + GAP_PX);
        x0 = ($urandom_range(0, 1) == 0) ? x0 - 1 + int'($urandom_range(0, 5))
                                         : x0 + PAD_W - 4 + int'($urandom_range(0, 5));
        y0 = ($urandom_range(0, 2) == 0) ? y0 - 1 + int'($urandom_range(0, 5))
             : (($urandom_range(0, 1) == 0) ? y0 + PAD_H - 4 + int'($urandom_range(0, 5))
                                            : y0 + int'($urandom_range(0, PAD_H - 1)));
        drive_px(x0, y0, $urandom_range(0, 7) != 0);
      end
      flash_valid = ($urandom_range(0, 3) == 0);
      flash_pad   = 2'($urandom_range(0, 3));
      tick(1'b0);
    end

    flash_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
